// File: rtl/temporal_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : temporal_pkg
//  Description : Shared types and constants for the temporal decode/encode
//                stages: default gamma length, field width, decoder state
//                encoding and the "no spike" sentinel.
//  Revision    : 1.0 - initial release
// ============================================================================
package temporal_pkg;

    // Samples per gamma cycle and the width needed to hold 0..G inclusive.
    localparam int GAMMA_CYCLE_WIDTH_DEFAULT = 16;
    localparam int TW_DEFAULT                = $clog2(GAMMA_CYCLE_WIDTH_DEFAULT + 1);

    // Per-gamma measurement state.
    typedef enum logic [1:0] {
        WAIT = 2'd0,    // no onset seen yet in this gamma
        HIGH = 2'd1,    // pulse in progress, width counting
        DONE = 2'd2     // measurement frozen until the gamma ends
    } dec_state_e;

    // The onset code reported when no pulse was seen: one past the last phase.
    function automatic int unsigned no_spike(input int unsigned gamma_len);
        return gamma_len;
    endfunction

endpackage : temporal_pkg
`default_nettype wire

// File: rtl/temporal_decoder_if.sv
`default_nettype none
// ============================================================================
//  Interface   : temporal_decoder_if
//  Description : Result channel of the temporal decoder: valid/ready handshake
//                carrying the onset phase and the pulse width of one gamma.
//  Revision    : 1.0 - initial release
// ============================================================================
interface temporal_decoder_if
    import temporal_pkg::*;
#(
    parameter int TW = TW_DEFAULT
) ();

    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] t_out;
    logic [TW-1:0] w_out;

    // Producer side (decoder).
    modport master (
        output out_valid,
        output t_out,
        output w_out,
        input  out_ready
    );

    // Consumer side (binary logic).
    modport slave (
        input  out_valid,
        input  t_out,
        input  w_out,
        output out_ready
    );

endinterface : temporal_decoder_if
`default_nettype wire

// File: rtl/temporal_decoder_gamma_counter.sv
`default_nettype none
// ============================================================================
//  Module      : gamma_counter
//  Description : Phase counter framing time into gamma cycles. Counts
//                0..GAMMA_CYCLE_WIDTH-1 and wraps; last_o flags the final
//                phase. Shared with the encoder stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module gamma_counter #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PW                = 5
) (
    input  wire logic          clk,
    input  wire logic          rst,
    output logic [PW-1:0]      phase_o,
    output logic               last_o
);

    localparam logic [PW-1:0] LAST_PHASE = PW'(GAMMA_CYCLE_WIDTH - 1);

    logic [PW-1:0] phase_q;

    // Advance one phase per clock, wrapping at the end of the gamma.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
        end else if (phase_q == LAST_PHASE) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_q + PW'(1);
        end
    end

    assign phase_o = phase_q;
    assign last_o  = (phase_q == LAST_PHASE);

endmodule : gamma_counter
`default_nettype wire

// File: rtl/temporal_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : temporal_decoder
//  Description : Samples a race-logic pulse once per clock, measures its onset
//                phase and width within each gamma cycle and publishes the pair
//                on a valid/ready channel. A result that cannot be delivered
//                because the previous one is still pending is dropped and
//                recorded in the sticky overflow flag.
//  Option      : TEMPORAL_DECODER_WIDTH_EN - when defined, pulse width is
//                tracked and reported on w_out; otherwise w_out is 0 and only
//                the onset is measured.
//  Revision    : 1.0 - initial release
// ============================================================================
module temporal_decoder
    import temporal_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = GAMMA_CYCLE_WIDTH_DEFAULT,
    parameter int TW                = $clog2(GAMMA_CYCLE_WIDTH + 1)
) (
    input  wire logic               aclk,
    input  wire logic               grst,
    input  wire logic               y,
    temporal_decoder_if.master      out_if,
    output logic                    overflow
);

    localparam logic [TW-1:0] NO_SPIKE = TW'(no_spike(GAMMA_CYCLE_WIDTH));

    logic [TW-1:0] phase;
    logic          last;

    dec_state_e    state_q, state_d;
    logic [TW-1:0] onset_q, onset_d;
    logic          prev_q;
    logic          out_valid_q;
    logic [TW-1:0] t_out_q;
    logic          overflow_q;
    logic [TW-1:0] t_pub_d;
`ifdef TEMPORAL_DECODER_WIDTH_EN
    logic [TW-1:0] run_cnt_q, run_cnt_d;
    logic [TW-1:0] w_out_q;
`endif

    gamma_counter #(
        .GAMMA_CYCLE_WIDTH (GAMMA_CYCLE_WIDTH),
        .PW                (TW)
    ) u_gamma_counter (
        .clk     (aclk),
        .rst     (grst),
        .phase_o (phase),
        .last_o  (last)
    );

    // Evaluate the measurement FSM for the sample taken on this edge.
    always_comb begin
        state_d   = state_q;
        onset_d   = onset_q;
`ifdef TEMPORAL_DECODER_WIDTH_EN
        run_cnt_d = run_cnt_q;
`endif
        case (state_q)
            WAIT: begin
                if (y && !prev_q) begin
                    onset_d   = phase;
`ifdef TEMPORAL_DECODER_WIDTH_EN
                    run_cnt_d = TW'(1);
                    state_d   = HIGH;
`else
                    state_d   = DONE;
`endif
                end
            end
`ifdef TEMPORAL_DECODER_WIDTH_EN
            HIGH: begin
                // Width cannot exceed G-onset, so the counter never wraps.
                if (y) begin
                    run_cnt_d = run_cnt_q + TW'(1);
                end else begin
                    state_d   = DONE;
                end
            end
`endif
            DONE:    state_d = DONE;
            default: state_d = WAIT;
        endcase
        t_pub_d = (state_d == WAIT) ? NO_SPIKE : onset_d;
    end

    // Measurement state, gamma-end publish and output handshake.
    always_ff @(posedge aclk) begin
        if (grst) begin
            state_q     <= WAIT;
            onset_q     <= '0;
            prev_q      <= 1'b0;
            out_valid_q <= 1'b0;
            t_out_q     <= '0;
            overflow_q  <= 1'b0;
`ifdef TEMPORAL_DECODER_WIDTH_EN
            run_cnt_q   <= '0;
            w_out_q     <= '0;
`endif
        end else begin
            if (last) begin
                // Start the next gamma clean; prev is forced low so a pulse
                // already high at phase 0 still registers as an onset.
                state_q   <= WAIT;
                onset_q   <= '0;
                prev_q    <= 1'b0;
`ifdef TEMPORAL_DECODER_WIDTH_EN
                run_cnt_q <= '0;
`endif
            end else begin
                state_q   <= state_d;
                onset_q   <= onset_d;
                prev_q    <= y;
`ifdef TEMPORAL_DECODER_WIDTH_EN
                run_cnt_q <= run_cnt_d;
`endif
            end

            if (last) begin
                if (!out_valid_q || out_if.out_ready) begin
                    out_valid_q <= 1'b1;
                    t_out_q     <= t_pub_d;
`ifdef TEMPORAL_DECODER_WIDTH_EN
                    w_out_q     <= run_cnt_d;
`endif
                end else begin
                    // Consumer still holds the previous result: keep it,
                    // drop the new one.
                    overflow_q  <= 1'b1;
                end
            end else if (out_valid_q && out_if.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.t_out     = t_out_q;
`ifdef TEMPORAL_DECODER_WIDTH_EN
    assign out_if.w_out     = w_out_q;
`else
    assign out_if.w_out     = '0;
`endif
    assign overflow         = overflow_q;

endmodule : temporal_decoder
`default_nettype wire

// File: tb/tb_temporal_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_temporal_decoder
//  Description : Self-checking bench for temporal_decoder: directed gamma
//                table, hand-written handshake/reset sequences and random
//                gammas compared against a per-gamma behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_temporal_decoder;

    localparam int G   = 16;
    localparam int TWL = 5;
`ifdef TEMPORAL_DECODER_WIDTH_EN
    localparam int WEN = 1;
`else
    localparam int WEN = 0;
`endif

    logic aclk = 1'b0;
    logic grst;
    logic y;
    logic overflow;

    temporal_decoder_if #(.TW(TWL)) bus ();

    temporal_decoder #(
        .GAMMA_CYCLE_WIDTH (G),
        .TW                (TWL)
    ) dut (
        .aclk     (aclk),
        .grst     (grst),
        .y        (y),
        .out_if   (bus),
        .overflow (overflow)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the samples of the current gamma plus output state.
    int m_phase;
    bit m_samp [G];
    bit m_valid;
    int m_t;
    int m_w;
    bit m_ovf;

    typedef struct {
        logic [15:0] pat;
        int          t;
        int          w;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Onset = first high sample, width = length of the run starting there.
    function automatic void measure(output int t, output int w);
        t = G;
        w = 0;
        for (int i = 0; i < G; i++) begin
            if (m_samp[i] && t == G) t = i;
        end
        if (t < G) begin
            for (int i = t; i < G; i++) begin
                if (!m_samp[i]) break;
                w++;
            end
        end
        w = w * WEN;
    endfunction

    task automatic check_model();
        check("out_valid", int'(bus.out_valid), int'(m_valid));
        check("t_out",     int'(bus.t_out),     m_t);
        check("w_out",     int'(bus.w_out),     m_w);
        check("overflow",  int'(overflow),      int'(m_ovf));
    endtask

    task automatic step(input bit yv, input bit rdy);
        int  t;
        int  w;
        bit  pub;
        y             = yv;
        bus.out_ready = rdy;
        @(posedge aclk);
        m_samp[m_phase] = yv;
        pub = (m_phase == G - 1);
        if (pub) begin
            measure(t, w);
            if (!m_valid || rdy) begin
                m_valid = 1'b1;
                m_t     = t;
                m_w     = w;
            end else begin
                m_ovf   = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        m_phase = pub ? 0 : m_phase + 1;
        #1 check_model();
    endtask

    task automatic do_reset();
        grst = 1'b1;
        y    = 1'b0;
        @(posedge aclk);
        m_phase = 0;
        m_valid = 1'b0;
        m_t     = 0;
        m_w     = 0;
        m_ovf   = 1'b0;
        #1 check_model();
        grst = 1'b0;
    endtask

    task automatic run_gamma(input logic [15:0] pat, input bit rdy);
        for (int i = 0; i < G; i++) step(pat[i], rdy);
    endtask

    // Watchdog: the bench never waits on a DUT event, but bound it anyway.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] tmp;
        int          o;
        int          wd;
        int          mode;
        int          rst_at;

        grst          = 1'b1;
        y             = 1'b0;
        bus.out_ready = 1'b0;

        vecs[0] = '{16'h0000,  16, 0};   // silent gamma
        vecs[1] = '{16'h03FC,   2, 8};   // phases 2..9
        vecs[2] = '{16'hFFFF,   0, 16};  // whole gamma high
        vecs[3] = '{16'hF000,  12, 4};   // truncated at gamma end
        vecs[4] = '{16'h0003,   0, 2};   // fresh onset right after
        vecs[5] = '{16'h0718,   3, 2};   // second pulse ignored

        // Reset state.
        do_reset();
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_ovf",   int'(overflow),      0);

        // Directed table, consumer always ready.
        foreach (vecs[k]) begin
            run_gamma(vecs[k].pat, 1'b1);
            check("tbl_valid", int'(bus.out_valid), 1);
            check("tbl_t",     int'(bus.t_out),     vecs[k].t);
            check("tbl_w",     int'(bus.w_out),     vecs[k].w * WEN);
        end

        // Back-pressure across two results: first held, overflow sticky.
        do_reset();
        run_gamma(16'h0004, 1'b0);
        check("bp_first_valid", int'(bus.out_valid), 1);
        check("bp_first_t",     int'(bus.t_out),     2);
        run_gamma(16'h0100, 1'b0);
        check("bp_hold_valid", int'(bus.out_valid), 1);
        check("bp_hold_t",     int'(bus.t_out),     2);
        check("bp_hold_w",     int'(bus.w_out),     1 * WEN);
        check("bp_ovf",        int'(overflow),      1);
        step(1'b0, 1'b1);
        check("bp_drop_valid", int'(bus.out_valid), 0);
        check("bp_ovf_sticky", int'(overflow),      1);
        check("bp_t_holds",    int'(bus.t_out),     2);
        step(1'b0, 1'b1);
        check("bp_ovf_sticky2", int'(overflow),     1);
        do_reset();
        check("bp_ovf_cleared", int'(overflow),     0);

        // Reset mid-pulse: nothing published, next gamma measured cleanly.
        for (int p = 0; p < 6; p++) step(p >= 4, 1'b1);
        do_reset();
        check("mid_rst_valid", int'(bus.out_valid), 0);
        for (int p = 0; p < G - 1; p++) begin
            step(p == 1 || p == 2, 1'b1);
            check("mid_rst_no_pub", int'(bus.out_valid), 0);
        end
        step(1'b0, 1'b1);
        check("mid_rst_next_valid", int'(bus.out_valid), 1);
        check("mid_rst_next_t",     int'(bus.t_out),     1);
        check("mid_rst_next_w",     int'(bus.w_out),     2 * WEN);

        // Random gammas with random back-pressure and occasional resets.
        do_reset();
        for (int g = 0; g < 60; g++) begin
            mode = $urandom_range(0, 3);
            case (mode)
                0: tmp = 32'($urandom);
                1, 3: begin
                    o   = $urandom_range(0, G - 1);
                    wd  = (mode == 3) ? G - o : $urandom_range(1, G - o);
                    tmp = ((32'd1 << wd) - 32'd1) << o;
                end
                default: tmp = 32'd0;
            endcase
            rst_at = ((g % 13) == 7) ? $urandom_range(1, G - 1) : G;
            for (int i = 0; i < G; i++) begin
                if (i == rst_at) begin
                    do_reset();
                    break;
                end
                step(tmp[i], $urandom_range(0, 3) != 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_temporal_decoder
`default_nettype wire
